lsu_access_ctrl: RTL and testbench

- Multi-cycle load/store sequencer between the MEM stage and the data-memory bus.
- Accepts one byte, half-word or word access at a time.
- Issues a word-aligned bus transaction with byte enables and waits for the bus acknowledge.
- For loads, selects the addressed byte or half-word lane and applies sign or zero extension. It holds `busy` high so the hazard unit stalls the pipeline.

---
 rtl/lsu_access_ctrl.sv | 165 ++++++++++++++++
 tb/tb_lsu_access_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_access_ctrl.sv
// Load/store sequencer between the MEM stage and the data-memory bus.
// Optional macro LSU_TIMEOUT_EN builds the bus_ack timeout counter and abort path.
module lsu_access_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic [1:0]  dbg_state
);
    // Handshake: a request is accepted on a rising edge where req_valid && req_ready;
    // rsp_valid is a single-cycle pulse and needs no ready from the MEM stage.

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

    state_t      state_q, state_d;
    logic        we_q, uns_q, err_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic        req_legal, take_req, take_ack, take_to, timeout_hit;
    logic [31:0] load_ext;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign req_legal = (req_size == 2'd0) ||
                       (req_size == 2'd1 && !req_addr[0]) ||
                       (req_size == 2'd2 && req_addr[1:0] == 2'b00);

`ifdef LSU_TIMEOUT_EN
    logic [7:0] cnt_q;
    assign timeout_hit = (cnt_q == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt_q <= 8'd0;
        else if (state_q == ACCESS && !bus_ack)
            cnt_q <= cnt_q + 8'd1;
        else
            cnt_q <= 8'd0;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        take_req = 1'b0;
        take_ack = 1'b0;
        take_to  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    take_req = 1'b1;
                    state_d  = req_legal ? ACCESS : RESP;
                end
            end
            ACCESS: begin
                // An ack in the timeout cycle still completes the access.
                if (bus_ack) begin
                    take_ack = 1'b1;
                    state_d  = RESP;
                end else if (timeout_hit) begin
                    take_to = 1'b1;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else if (take_req) begin
            we_q    <= req_we;
            uns_q   <= req_unsigned;
            size_q  <= req_size;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            rdata_q <= 32'd0;
            err_q   <= !req_legal;
        end else if (take_ack) begin
            rdata_q <= we_q ? 32'd0 : load_ext;
            err_q   <= 1'b0;
        end else if (take_to) begin
            rdata_q <= 32'd0;
            err_q   <= 1'b1;
        end
    end

    // Little-endian lane selection and extension of the load result.
    always_comb begin
        lane_b   = bus_rdata[{addr_q[1:0], 3'b000} +: 8];
        lane_h   = bus_rdata[{addr_q[1], 4'b0000} +: 16];
        load_ext = bus_rdata;
        case (size_q)
            2'd0:    load_ext = uns_q ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
            2'd1:    load_ext = uns_q ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: load_ext = bus_rdata;
        endcase
    end

    always_comb begin
        be_c    = 4'b0000;
        wdata_c = wdata_q;
        case (size_q)
            2'd0: begin
                be_c    = 4'b0001 << addr_q[1:0];
                wdata_c = {4{wdata_q[7:0]}};
            end
            2'd1: begin
                be_c    = 4'b0011 << {addr_q[1], 1'b0};
                wdata_c = {2{wdata_q[15:0]}};
            end
            2'd2:    be_c = 4'b1111;
            default: be_c = 4'b0000;
        endcase
    end

    assign bus_req   = (state_q == ACCESS);
    assign bus_we    = bus_req & we_q;
    assign bus_addr  = bus_req ? {addr_q[31:2], 2'b00} : 32'd0;
    assign bus_be    = bus_req ? be_c : 4'b0000;
    assign bus_wdata = bus_req ? wdata_c : 32'd0;
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp_valid ? rdata_q : 32'd0;
    assign rsp_err   = rsp_valid & err_q;
    assign busy      = (state_q != IDLE);
    assign req_ready = (state_q == IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_lsu_access_ctrl.sv
// Self-checking bench for lsu_access_ctrl: directed cases plus randomized accesses
// against an arithmetic reference model. Define LSU_TIMEOUT_EN to cover the abort path.
module tb_lsu_access_ctrl;

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned TB_TIMEOUT = 4;
    localparam bit          TO_EN      = 1'b1;
`else
    localparam int unsigned TB_TIMEOUT = 255;
    localparam bit          TO_EN      = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'd0;
    logic        rsp_valid, rsp_err, busy;
    logic [31:0] rsp_rdata;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    lsu_access_ctrl #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .busy(busy), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=0x%08h expected=0x%08h @%0t", tag, obs, exp, $time);
        end
    endtask

    // reference model
    function automatic bit model_legal(input logic [1:0] size, input logic [31:0] addr);
        if (size == 2'd3) return 1'b0;
        if (size == 2'd1) return (addr % 2) == 0;
        if (size == 2'd2) return (addr % 4) == 0;
        return 1'b1;
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] size, input logic [31:0] addr);
        int unsigned v;
        v = 0;
        if (size == 2'd0) v = 1 << (addr % 4);
        else if (size == 2'd1) v = 3 << (((addr / 2) % 2) * 2);
        else if (size == 2'd2) v = 15;
        return v[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] wd);
        if (size == 2'd0) return (wd & 32'hFF) * 32'h0101_0101;
        if (size == 2'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                               input logic [31:0] addr, input logic [31:0] rd);
        int unsigned sh, bits;
        logic [31:0] mask, v;
        if (size == 2'd2) return rd;
        bits = (size == 2'd0) ? 8 : 16;
        sh   = (size == 2'd0) ? 8 * (addr % 4) : 16 * ((addr / 2) % 2);
        mask = (32'd1 << bits) - 32'd1;
        v    = (rd >> sh) & mask;
        if (!uns && v[bits-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_rsp_valid_low"}, rsp_valid, 1'b0);
        check({tag, "_req_ready"}, req_ready, 1'b1);
        check({tag, "_busy_low"}, busy, 1'b0);
    endtask

    // driver: one full access, ack after ack_delay wait cycles
    task automatic do_access(input string tag, input logic we, input logic [1:0] size,
                             input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                             input int unsigned ack_delay, input logic [31:0] rd);
        bit legal, to;
        int unsigned req_cycles;
        logic [31:0] exp_rd;
        legal = model_legal(size, addr);
        to    = legal && TO_EN && (ack_delay >= TB_TIMEOUT);
        req_cycles = to ? TB_TIMEOUT : ack_delay + 1;
        exp_rd = (!legal || to || we) ? 32'd0 : model_load(size, uns, addr, rd);
        exp_q.push_back(exp_rd);

        @(negedge clk);
        check({tag, "_ready_before"}, req_ready, 1'b1);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        if (legal) begin
            for (int i = 0; i < int'(req_cycles); i++) begin
                check({tag, "_bus_req"}, bus_req, 1'b1);
                check({tag, "_busy"}, busy, 1'b1);
                check({tag, "_bus_we"}, bus_we, we);
                check({tag, "_bus_addr"}, bus_addr, {addr[31:2], 2'b00});
                check({tag, "_bus_be"}, bus_be, model_be(size, addr));
                check({tag, "_bus_wdata"}, bus_wdata, model_wdata(size, wd));
                bus_ack   = (i == int'(ack_delay));
                bus_rdata = bus_ack ? rd : $urandom;
                @(negedge clk);
            end
            bus_ack   = 1'b0;
            bus_rdata = $urandom;
        end else begin
            check({tag, "_no_bus_req"}, bus_req, 1'b0);
        end
        check({tag, "_rsp_valid"}, rsp_valid, 1'b1);
        check({tag, "_rsp_err"}, rsp_err, !legal || to);
        check({tag, "_rsp_busy"}, busy, 1'b1);
        check({tag, "_rsp_bus_idle"}, bus_req, 1'b0);
        if (exp_q.size() > 0) check({tag, "_rsp_rdata"}, rsp_rdata, exp_q.pop_front());
        @(negedge clk);
        check_idle(tag);
    endtask

    initial begin
        // reset state
        #1;
        check("rst_bus_req", bus_req, 1'b0);
        check("rst_bus_we", bus_we, 1'b0);
        check("rst_bus_addr", bus_addr, 32'd0);
        check("rst_bus_be", bus_be, 4'd0);
        check("rst_bus_wdata", bus_wdata, 32'd0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_err", rsp_err, 1'b0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_req_ready", req_ready, 1'b1);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // directed cases
        do_access("lb_signed", 1'b0, 2'd0, 1'b0, 32'h0000_1003, 32'd0, 0, 32'h80AA_BBCC);
        do_access("lhu", 1'b0, 2'd1, 1'b1, 32'h0000_2002, 32'd0, 0, 32'h9ABC_1234);
        do_access("sb", 1'b1, 2'd0, 1'b0, 32'h0000_0001, 32'h1234_56EF, 3, 32'hDEAD_BEEF);
        do_access("misaligned_w", 1'b0, 2'd2, 1'b0, 32'h0000_0006, 32'd0, 0, 32'd0);
        do_access("misaligned_h", 1'b1, 2'd1, 1'b0, 32'h0000_0103, 32'h55, 0, 32'd0);
        do_access("size3", 1'b0, 2'd3, 1'b0, 32'h0000_0000, 32'd0, 0, 32'd0);
        do_access("lw", 1'b0, 2'd2, 1'b0, 32'h0000_4000, 32'd0, 2, 32'hCAFE_F00D);
        do_access("lh_signed_lo", 1'b0, 2'd1, 1'b0, 32'h0000_0010, 32'd0, 1, 32'h1234_8001);
        do_access("sh_hi", 1'b1, 2'd1, 1'b0, 32'h0000_0022, 32'hAAAA_5A5A, 0, 32'd0);
`ifdef LSU_TIMEOUT_EN
        do_access("timeout", 1'b0, 2'd2, 1'b0, 32'h0000_0040, 32'd0, 50, 32'd0);
        do_access("ack_at_timeout", 1'b0, 2'd0, 1'b1, 32'h0000_0042, 32'd0,
                  TB_TIMEOUT - 1, 32'h00F0_0000);
`endif

        // reset asserted mid-access
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h0000_0080;
        @(negedge clk);
        req_valid = 1'b0;
        check("midrst_bus_req_before", bus_req, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("midrst_bus_req_drop", bus_req, 1'b0);
        check("midrst_ready", req_ready, 1'b1);
        check("midrst_busy", busy, 1'b0);
        bus_ack = 1'b1; bus_rdata = 32'h1111_2222;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_no_rsp", rsp_valid, 1'b0);
        end
        bus_ack = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check_idle("after_rst");
        do_access("lw_after_rst", 1'b0, 2'd2, 1'b0, 32'h0000_0000, 32'd0, 0, 32'h7654_3210);

        // randomized accesses
        for (int n = 0; n < 80; n++) begin
            logic [1:0]  sz;
            logic [31:0] a;
            sz = 2'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            do_access("rand", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                      a, $urandom, $urandom_range(0, 6), $urandom);
        end

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
